// File: rtl/f15_fftshift_pkg.sv
// f15_fftshift_pkg
// Shared definitions for the FFT-shift frame gate:
//   MIN_LOG2    smallest supported log2 frame length
//   wr_state_t  write-side FSM encoding (IDLE=0, FILL=1, DISCARD=2)
//   clamp_log2  clamps a requested log2 frame length into [lo, hi]
package f15_fftshift_pkg;

    localparam int MIN_LOG2 = 4;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_FILL    = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_t;

    function automatic logic [3:0] clamp_log2(input logic [3:0] req,
                                              input logic [3:0] lo,
                                              input logic [3:0] hi);
        if (req < lo) begin
            return lo;
        end else if (req > hi) begin
            return hi;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/f15_fftshift_gate_ram.sv
// f15_dp_ram
// Simple dual-port RAM: one write port, one read port with a registered
// output (1-cycle latency). The read register holds its value when rd_en
// is low.
// Ports:
//   clk               clock
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr           read request
//   rd_data                 read data, valid the cycle after rd_en
module f15_dp_ram #(
    parameter int ADDR_W = 11,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/f15_fftshift_gate.sv
// f15_fftshift_gate
// Frame conditioner in front of the fosphor core. Incoming FFT frames are
// length-checked; malformed frames are dropped and counted. Good frames are
// stored in one of two RAM banks and replayed, optionally FFT-shifted, with
// tlast on the final bin.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cfg_log2_len, cfg_shift         frame length (log2, clamped) and shift enable
//   i_tdata/i_tlast/i_tvalid/i_tready   input stream from the FFT
//   o_tdata/o_tlast/o_tvalid/o_tready   output stream to the core
//   stat_drop_cnt                   saturating dropped-frame counter
module f15_fftshift_gate #(
    parameter int AWIDTH   = 10,
    parameter int DWIDTH   = 32,
    parameter int MIN_LOG2 = f15_fftshift_pkg::MIN_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cfg_log2_len,
    input  logic              cfg_shift,
    input  logic [DWIDTH-1:0] i_tdata,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [DWIDTH-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [15:0]       stat_drop_cnt
);

    import f15_fftshift_pkg::*;

    localparam int LW = AWIDTH + 1;

    function automatic logic [AWIDTH-1:0] len_m1_of(input logic [3:0] lg);
        logic [LW-1:0] len;
        len = LW'(1) << lg;
        return AWIDTH'(len - LW'(1));
    endfunction

    function automatic logic [AWIDTH-1:0] half_of(input logic [3:0] lg);
        logic [LW-1:0] len;
        len = LW'(1) << lg;
        return AWIDTH'(len >> 1);
    endfunction

    wr_state_t         wr_state, wr_next;
    logic              wr_bank, rd_bank, iss_bank;
    logic [1:0]        full;
    logic [1:0][3:0]   bank_lg;
    logic [1:0]        bank_sh;
    logic [AWIDTH-1:0] wr_cnt, wr_len_m1, iss_cnt;
    logic [15:0]       drop_cnt;
    logic [3:0]        cfg_lg_clamped;
    logic              i_fire, wr_en, frame_good, frame_drop;

    logic              rd_issue, iss_last, ram_vld, ram_last;
    logic [AWIDTH-1:0] iss_len_m1, iss_xor;
    logic [DWIDTH-1:0] ram_rdata;
    logic [1:0][DWIDTH-1:0] buf_data;
    logic [1:0]        buf_last;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ;
    logic              pop, release_bank;

    assign cfg_lg_clamped = clamp_log2(cfg_log2_len, 4'(MIN_LOG2), 4'(AWIDTH));

    // DISCARD keeps swallowing beats even when the target bank is occupied.
    assign i_tready = !reset && ((wr_state == WR_DISCARD) || !full[wr_bank]);
    assign i_fire   = i_tvalid && i_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= WR_IDLE;
        end else begin
            wr_state <= wr_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: begin
                if (i_fire && !i_tlast) begin
                    wr_next = WR_FILL;
                end
            end
            WR_FILL: begin
                if (i_fire) begin
                    if (wr_cnt == wr_len_m1) begin
                        wr_next = i_tlast ? WR_IDLE : WR_DISCARD;
                    end else if (i_tlast) begin
                        wr_next = WR_IDLE;
                    end
                end
            end
            WR_DISCARD: begin
                if (i_fire && i_tlast) begin
                    wr_next = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // A tlast on the very first beat is a length-1 frame and counts as short.
    always_comb begin
        wr_en      = 1'b0;
        frame_good = 1'b0;
        frame_drop = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                wr_en      = i_fire;
                frame_drop = i_fire && i_tlast;
            end
            WR_FILL: begin
                wr_en = i_fire;
                if (i_fire && i_tlast) begin
                    if (wr_cnt == wr_len_m1) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_drop = 1'b1;
                    end
                end
            end
            WR_DISCARD: begin
                frame_drop = i_fire && i_tlast;
            end
            default: ;
        endcase
    end

    // Config is captured only on the first beat, so mid-frame changes
    // apply to the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt    <= '0;
            wr_len_m1 <= '0;
            bank_lg   <= '0;
            bank_sh   <= '0;
        end else if (wr_state == WR_IDLE && i_fire) begin
            bank_lg[wr_bank] <= cfg_lg_clamped;
            bank_sh[wr_bank] <= cfg_shift;
            wr_len_m1        <= len_m1_of(cfg_lg_clamped);
            wr_cnt           <= AWIDTH'(1);
        end else if (wr_state == WR_FILL && i_fire) begin
            wr_cnt <= wr_cnt + AWIDTH'(1);
        end
    end

    // Completion and release always target different banks, so both
    // updates can land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= !rd_bank;
            end
            if (frame_good) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= !wr_bank;
            end
            if (frame_drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign stat_drop_cnt = drop_cnt;

    // Read issue runs ahead of release: once every address of a bank has
    // been issued, iss_bank moves on so the next full bank streams without
    // a gap while the tail of the previous one is still in the skid buffer.
    assign iss_len_m1 = len_m1_of(bank_lg[iss_bank]);
    assign iss_xor    = bank_sh[iss_bank] ? half_of(bank_lg[iss_bank]) : '0;
    assign iss_last   = (iss_cnt == iss_len_m1);

    assign o_tvalid = (buf_cnt != 2'd0);
    assign pop      = o_tvalid && o_tready;
    assign occ      = {1'b0, buf_cnt} + {2'b00, ram_vld} - {2'b00, pop};
    assign rd_issue = full[iss_bank] && (occ < 3'd2);
    assign release_bank = pop && buf_last[0];

    f15_dp_ram #(
        .ADDR_W (AWIDTH + 1),
        .DWIDTH (DWIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, (wr_state == WR_IDLE) ? AWIDTH'(0) : wr_cnt}),
        .wr_data (i_tdata),
        .rd_en   (rd_issue),
        .rd_addr ({iss_bank, iss_cnt ^ iss_xor}),
        .rd_data (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_bank <= 1'b0;
            iss_cnt  <= '0;
            ram_vld  <= 1'b0;
            ram_last <= 1'b0;
        end else begin
            ram_vld  <= rd_issue;
            ram_last <= rd_issue && iss_last;
            if (rd_issue) begin
                if (iss_last) begin
                    iss_cnt  <= '0;
                    iss_bank <= !iss_bank;
                end else begin
                    iss_cnt <= iss_cnt + AWIDTH'(1);
                end
            end
        end
    end

    // Two-entry skid buffer; entry 0 is the head driven onto the output.
    // The issue credit check guarantees a push never arrives while both
    // entries are held.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_data <= '0;
            buf_last <= '0;
            buf_cnt  <= 2'd0;
        end else begin
            case (buf_cnt)
                2'd0: begin
                    if (ram_vld) begin
                        buf_data[0] <= ram_rdata;
                        buf_last[0] <= ram_last;
                        buf_cnt     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (ram_vld && pop) begin
                        buf_data[0] <= ram_rdata;
                        buf_last[0] <= ram_last;
                    end else if (ram_vld) begin
                        buf_data[1] <= ram_rdata;
                        buf_last[1] <= ram_last;
                        buf_cnt     <= 2'd2;
                    end else if (pop) begin
                        buf_cnt <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        buf_data[0] <= buf_data[1];
                        buf_last[0] <= buf_last[1];
                        if (ram_vld) begin
                            buf_data[1] <= ram_rdata;
                            buf_last[1] <= ram_last;
                        end else begin
                            buf_cnt <= 2'd1;
                        end
                    end
                end
                default: buf_cnt <= 2'd0;
            endcase
        end
    end

    assign o_tdata = buf_data[0];
    assign o_tlast = buf_last[0] && o_tvalid;

endmodule

// File: tb/tb_f15_fftshift_gate.sv
// tb_f15_fftshift_gate
// Directed self-checking bench for f15_fftshift_gate. Inputs are driven on
// the falling edge; a monitor on the falling edge records every output beat
// that will transfer on the following rising edge.
module tb_f15_fftshift_gate;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cfg_log2_len = 4'd4;
    logic        cfg_shift = 1'b0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b0;
    logic [15:0] stat_drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int exp_drops = 0;
    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];
    int out_cyc[$];

    f15_fftshift_gate #(
        .AWIDTH   (10),
        .DWIDTH   (32),
        .MIN_LOG2 (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_log2_len  (cfg_log2_len),
        .cfg_shift     (cfg_shift),
        .i_tdata       (i_tdata),
        .i_tlast       (i_tlast),
        .i_tvalid      (i_tvalid),
        .i_tready      (i_tready),
        .o_tdata       (o_tdata),
        .o_tlast       (o_tlast),
        .o_tvalid      (o_tvalid),
        .o_tready      (o_tready),
        .stat_drop_cnt (stat_drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        case (rdy_mode)
            0:       o_tready = 1'b0;
            1:       o_tready = 1'b1;
            default: o_tready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (o_tvalid === 1'b1 && o_tready === 1'b1 && reset === 1'b0) begin
            out_q.push_back({o_tlast, o_tdata});
            out_cyc.push_back(cyc);
        end
    end

    task automatic send_frame(input int len, input logic [3:0] lg, input logic sh,
                              input logic [31:0] base);
        int guard;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cfg_log2_len = lg;
                cfg_shift    = sh;
            end else if (i == 1) begin
                cfg_log2_len = lg ^ 4'd1;
                cfg_shift    = ~sh;
            end
            i_tvalid = 1'b1;
            i_tdata  = base + 32'(i);
            i_tlast  = (i == len - 1);
            #1;
            guard = 0;
            while (i_tready !== 1'b1 && guard < 3000) begin
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard >= 3000) begin
                checks++;
                errors++;
                $display("[TB] FAIL send_timeout beat %0d got i_tready=%b want 1", i, i_tready);
                i_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic input_idle();
        @(negedge clk);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic add_exp(input int lg, input logic sh, input logic [31:0] base);
        int len;
        int idx;
        logic lastb;
        len = 1 << lg;
        for (int k = 0; k < len; k++) begin
            idx   = sh ? (k ^ (len / 2)) : k;
            lastb = (k == len - 1);
            exp_q.push_back({lastb, base + 32'(idx)});
        end
    endtask

    task automatic wait_out(input int n, output bit ok);
        int g;
        g = 0;
        while (out_q.size() < n && g < 20000) begin
            @(negedge clk);
            g++;
        end
        ok = (out_q.size() >= n);
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_queues();
        out_q.delete();
        exp_q.delete();
        out_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (i_tready !== 1'b0) begin errors++; $display("[TB] FAIL rst_itready got %b want 0", i_tready); end
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_otvalid got %b want 0", o_tvalid); end
        checks++; if (o_tlast !== 1'b0) begin errors++; $display("[TB] FAIL rst_otlast got %b want 0", o_tlast); end
        checks++; if (o_tdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_otdata got %h want 0", o_tdata); end
        checks++; if (stat_drop_cnt !== 16'h0) begin errors++; $display("[TB] FAIL rst_drop got %0d want 0", stat_drop_cnt); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (i_tready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_itready got %b want 1", i_tready); end
    endtask

    task automatic test_basic();
        bit ok;
        clear_queues();
        rdy_mode = 1;
        add_exp(4, 1'b0, 32'h0);
        send_frame(16, 4'd4, 1'b0, 32'h0);
        input_idle();
        #1;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL latency_n1 got %b want 0", o_tvalid); end
        @(negedge clk); #1;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL latency_n2 got %b want 0", o_tvalid); end
        @(negedge clk); #1;
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL latency_n3 got %b want 1", o_tvalid); end
        wait_out(exp_q.size(), ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_wait got %0d beats want %0d", out_q.size(), exp_q.size()); end
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL basic_count got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL basic_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_shift();
        bit ok;
        clear_queues();
        rdy_mode = 1;
        add_exp(4, 1'b1, 32'h100);
        send_frame(16, 4'd4, 1'b1, 32'h100);
        input_idle();
        wait_out(exp_q.size(), ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL shift_wait got %0d beats want %0d", out_q.size(), exp_q.size()); end
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL shift_count got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL shift_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_drops();
        bit ok;
        clear_queues();
        rdy_mode = 1;
        send_frame(10, 4'd4, 1'b0, 32'h200);
        exp_drops++;
        send_frame(20, 4'd4, 1'b0, 32'h300);
        exp_drops++;
        add_exp(4, 1'b0, 32'h400);
        send_frame(16, 4'd4, 1'b0, 32'h400);
        input_idle();
        wait_out(exp_q.size(), ok);
        checks++; if (stat_drop_cnt !== 16'(exp_drops)) begin errors++; $display("[TB] FAIL drop_cnt2 got %0d want %0d", stat_drop_cnt, exp_drops); end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL drops_wait got %0d beats want %0d", out_q.size(), exp_q.size()); end
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL drops_count got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL drops_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        send_frame(1, 4'd4, 1'b0, 32'h500);
        exp_drops++;
        input_idle();
        repeat (10) @(negedge clk);
        #1;
        checks++; if (stat_drop_cnt !== 16'(exp_drops)) begin errors++; $display("[TB] FAIL drop_len1 got %0d want %0d", stat_drop_cnt, exp_drops); end
        checks++; if (out_q.size() != 16) begin errors++; $display("[TB] FAIL drop_len1_out got %0d beats want 16", out_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_queues();
        rdy_mode = 0;
        for (int f = 0; f < 4; f++) add_exp(4, 1'(f % 2), 32'h1000 * (f + 1));
        send_frame(16, 4'd4, 1'b0, 32'h1000);
        send_frame(16, 4'd4, 1'b1, 32'h2000);
        input_idle();
        #1;
        checks++; if (i_tready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_block got %b want 0", i_tready); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (i_tready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_block_hold got %b want 0", i_tready); end
        checks++; if (out_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_stalled_out got %0d want 0", out_q.size()); end
        fork
            begin
                send_frame(16, 4'd4, 1'b0, 32'h3000);
                send_frame(16, 4'd4, 1'b1, 32'h4000);
                input_idle();
            end
            begin
                repeat (6) @(negedge clk);
                rdy_mode = 1;
            end
        join
        wait_out(exp_q.size(), ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_wait got %0d beats want %0d", out_q.size(), exp_q.size()); end
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL b2b_count got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        for (int i = 1; i < 64 && i < out_cyc.size(); i++) begin
            if (i != 32 && i != 48) begin
                checks++;
                if (out_cyc[i] != out_cyc[i-1] + 1) begin
                    errors++;
                    $display("[TB] FAIL b2b_bubble beat%0d got cycle %0d want %0d", i, out_cyc[i], out_cyc[i-1] + 1);
                end
            end
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        int lg;
        int len;
        logic sh;
        logic [31:0] base;
        clear_queues();
        rdy_mode = 2;
        for (int f = 0; f < 100; f++) begin
            lg   = $urandom_range(4, 5);
            sh   = 1'($urandom_range(0, 1));
            base = 32'(f + 1) << 16;
            len  = 1 << lg;
            if (f % 10 == 3) begin
                send_frame(len - 5, 4'(lg), sh, base);
                exp_drops++;
            end else if (f % 10 == 7) begin
                send_frame(len + 3, 4'(lg), sh, base);
                exp_drops++;
            end else begin
                add_exp(lg, sh, base);
                send_frame(len, 4'(lg), sh, base);
            end
        end
        input_idle();
        wait_out(exp_q.size(), ok);
        rdy_mode = 1;
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rand_wait got %0d beats want %0d", out_q.size(), exp_q.size()); end
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand_count got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        checks++; if (stat_drop_cnt !== 16'(exp_drops)) begin errors++; $display("[TB] FAIL rand_drop got %0d want %0d", stat_drop_cnt, exp_drops); end
    endtask

    task automatic test_clamp();
        bit ok;
        clear_queues();
        rdy_mode = 1;
        add_exp(4, 1'b0, 32'h7000);
        send_frame(16, 4'd2, 1'b0, 32'h7000);
        add_exp(10, 1'b1, 32'h8000);
        send_frame(1024, 4'd15, 1'b1, 32'h8000);
        input_idle();
        wait_out(exp_q.size(), ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL clamp_wait got %0d beats want %0d", out_q.size(), exp_q.size()); end
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL clamp_count got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL clamp_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
        checks++; if (stat_drop_cnt !== 16'(exp_drops)) begin errors++; $display("[TB] FAIL clamp_drop got %0d want %0d", stat_drop_cnt, exp_drops); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_queues();
        rdy_mode = 0;
        send_frame(16, 4'd4, 1'b0, 32'h9000);
        input_idle();
        repeat (4) @(negedge clk);
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        rdy_mode = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (i_tready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_itready got %b want 0", i_tready); end
        @(negedge clk);
        #1;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_otvalid got %b want 0", o_tvalid); end
        checks++; if (stat_drop_cnt !== 16'h0) begin errors++; $display("[TB] FAIL rmid_drop got %0d want 0", stat_drop_cnt); end
        checks++; if (o_tdata !== 32'h0) begin errors++; $display("[TB] FAIL rmid_otdata got %h want 0", o_tdata); end
        reset = 1'b0;
        exp_drops = 0;
        #1;
        checks++; if (i_tready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_release_itready got %b want 1", i_tready); end
        clear_queues();
        rdy_mode = 1;
        add_exp(4, 1'b1, 32'hA000);
        send_frame(16, 4'd4, 1'b1, 32'hA000);
        input_idle();
        wait_out(exp_q.size(), ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_wait got %0d beats want %0d", out_q.size(), exp_q.size()); end
        checks++; if (out_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rmid_count got %0d want %0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rmid_beat%0d got %h want %h", i, out_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting f15_fftshift_gate bench");
        test_reset();
        test_basic();
        test_shift();
        test_drops();
        test_back_to_back();
        test_random_ready();
        test_clamp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f15_fftshift_gate.md
# f15_fftshift_gate

Frame conditioner that sits directly upstream of the fosphor core, between the FFT output stream and the core's 32-bit complex input. It checks every incoming FFT frame against the configured length and silently drops malformed frames. Good frames are stored in a ping-pong buffer and replayed with an optional FFT-shift, so DC lands mid-line. The core therefore only ever sees whole, correctly sized frames with `tlast` on the final bin.

## Interface
- `AWIDTH`, 10: log2 of the maximum frame length. Each bank holds 2^AWIDTH words; 10 matches the core's line address width.
- `DWIDTH`, 32: sample width, `{real[15:0], imag[15:0]}`.
- `MIN_LOG2`, 4: smallest supported log2 frame length.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `cfg_log2_len`  in  4  log2 frame length. Values are clamped to [MIN_LOG2, AWIDTH].
- `cfg_shift`  in  1  1 = FFT-shift on output.
- `i_tdata` / `i_tlast` / `i_tvalid`  in  DWIDTH/1/1  AXI-stream input from the FFT.
- `i_tready`  out  1  input ready.
- `o_tdata` / `o_tlast` / `o_tvalid`  out  DWIDTH/1/1  AXI-stream output to the core.
- `o_tready`  in  1  output ready.
- `stat_drop_cnt`  out  16  saturating count of dropped frames.

## Operation
- **Banks.** Two banks, each with a `full` flag and a latched `{log2_len, shift}` pair.
  - Write pointer `wr_bank`, read pointer `rd_bank`.
- **Write FSM, states IDLE / FILL / DISCARD.**
  - IDLE: on the first accepted beat, latch the clamped config into `wr_bank`, write word 0, set `wr_cnt = 1`, go to FILL.
  - FILL, beat with `tlast` at index `len-1`: the frame is good. Set `full[wr_bank]`, toggle `wr_bank`, go to IDLE.
  - FILL, beat with `tlast` at index `< len-1`: the frame is short. Drop it, increment `stat_drop_cnt`, go to IDLE. The bank stays empty.
  - FILL, beat at index `len-1` without `tlast`: the frame is long. Go to DISCARD.
  - DISCARD: accept and drop all beats. On `tlast`, increment `stat_drop_cnt` and go to IDLE.
  - A frame of length 1 (`tlast` on the first beat in IDLE) is a short frame.
- **`i_tready`.** Asserted in DISCARD, or when `full[wr_bank] == 0`. Otherwise deasserted.
- **Read side.** When `full[rd_bank]`, read RAM address `rd_cnt ^ (shift ? len>>1 : 0)` for `rd_cnt = 0 .. len-1`, i.e. invert the index MSB when shifting.
  - `o_tlast` is asserted on `rd_cnt == len-1`.
  - When the last beat is accepted at the output, clear `full[rd_bank]` and toggle `rd_bank`.
- **Output buffer.** The 1-cycle RAM read feeds a 2-entry output skid buffer. RAM reads are issued only when the buffer can absorb the result, so no beat is ever lost or duplicated under any `o_tready` pattern.
- **Simultaneous events.**
  - Write-side completion and read-side release in the same cycle act on different banks and both take effect.
  - A write into the bank being released in that same cycle is impossible, because `i_tready` reflects the registered `full` flag.
- **Config changes.** Changes mid-frame affect only the next frame started.
- **Drop counter.** Saturates at 0xFFFF; no wrap.
- **Reset values.** Reset, at any point, discards all buffered data and gives:
  - `full = 0`, both bank pointers 0, FSM in IDLE;
  - `i_tready = 0` during reset, 1 the cycle after;
  - `o_tvalid = 0`, `o_tlast = 0`, `o_tdata = 0`, `stat_drop_cnt = 0`.

## Timing
- Input throughput is 1 beat/cycle while a bank is free. A frame of length L is fully accepted in L cycles.
- Latency: with `o_tready` high, `o_tvalid` for word 0 asserts 2 cycles after the edge that accepts the good frame's last beat. Cycle N+1 sets `full` and issues the RAM read; cycle N+2 presents the data.
- With `o_tready` held high, output is 1 beat/cycle. Back-to-back full banks stream with zero bubble cycles between frames.
- `o_tdata` / `o_tlast` are held stable while `o_tvalid & ~o_tready`.

## Structure
- Shared package `f15_fftshift_pkg`:
  - `MIN_LOG2`;
  - FSM state encoding (IDLE=0, FILL=1, DISCARD=2);
  - the clamp function for `cfg_log2_len`.
- Sub-module `f15_dp_ram`: simple dual-port RAM, one write port and one registered read port (1-cycle latency), depth 2^(AWIDTH+1), DWIDTH wide. The bank is the address MSB.
- The skid buffer and both FSMs stay in the top module.

## Test plan
- `cfg_log2_len=4`, `cfg_shift=0`; send one 16-beat frame with data = index, `o_tready=1` -> output 0..15 in order, `tlast` on 15, first `o_tvalid` exactly 2 cycles after the input `tlast` accept.
- Same frame with `cfg_shift=1` -> output order 8..15, 0..7, `tlast` on the beat carrying 7.
- Send a 10-beat frame, then a 20-beat frame, then a good 16-beat frame -> `stat_drop_cnt` ends at 2, and only the good frame appears at the output.
- Send 4 back-to-back good frames with `o_tready=0`, then release it -> `i_tready` drops after 2 frames; all 4 frames are output intact with no inter-frame bubble.
- Random `o_tready` (50%) over 100 frames -> output matches the reference-model sequence beat for beat; no loss or duplication.
- Assert `reset` mid-output with one bank full -> the cycle after, `o_tvalid=0` and `stat_drop_cnt=0`; a new good frame then passes normally.
